// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the wait-state data memory.
package data_mem_pkg;

    localparam int unsigned BYTE_LANES = 4;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        SZ_WORD = 1'b0,
        SZ_BYTE = 1'b1
    } size_t;

    // Request latched at acceptance and consumed at completion.
    typedef struct packed {
        logic              is_write;
        size_t             size;
        logic [1:0]        lane;
        logic [WORD_W-1:0] wdata;
        logic              ok;
    } req_t;

    // True iff base <= addr < base + 4*depth; the offset is checked in words so it cannot overflow.
    function automatic logic range_ok(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ((off >> 2) < depth);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array with per-byte write enables.
//   clk   : write clock
//   be    : byte write enables, one per lane (synchronous write)
//   idx   : word index for both read and write
//   wdata : write data, lane i taken from wdata[8i+7:8i]
//   rdata : combinational read of mem[idx]
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
)(
    input  logic                  clk,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [IDX_W-1:0]      idx,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BYTE_LANES); i++) begin
            if (be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_memory_ws.sv
// Data memory stage with programmable wait states and a ready/valid handshake.
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset
//   mem_r_en : read request            mem_w_en : write request
//   size     : 0 word, 1 byte          addr     : byte address
//   wr_data  : store data (byte store uses [7:0])
//   ready    : idle, request may be accepted (upstream freeze = ~ready)
//   rd_data  : read result, byte reads zero-extended, held between reads
//   rd_valid : one-cycle pulse on read completion
//   addr_err : one-cycle pulse when an accepted request was invalid
module data_memory_ws
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              size,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    req_t                  req, req_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic                  ready_n, rd_valid_n, addr_err_n;
    logic [DATA_W-1:0]     rd_data_n;

    logic [BYTE_LANES-1:0] be_c;
    logic [WORD_W-1:0]     wdata_c;
    logic [WORD_W-1:0]     rdata_c;
    logic                  req_ok_c;

    // Validity of the request currently on the inputs.
    assign req_ok_c = range_ok(addr, 32'(BASE_ADDR), 32'(DEPTH))
                      && ((size_t'(size) == SZ_BYTE) || (addr[1:0] == 2'b00))
                      && !(mem_r_en && mem_w_en);

    // A reset on the completion edge must suppress the write.
    data_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .be    (be_c & {BYTE_LANES{rst}}),
        .idx   (idx),
        .wdata (wdata_c),
        .rdata (rdata_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            req      <= '0;
            idx      <= '0;
            ready    <= 1'b1;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            req      <= req_n;
            idx      <= idx_n;
            ready    <= ready_n;
            rd_data  <= rd_data_n;
            rd_valid <= rd_valid_n;
            addr_err <= addr_err_n;
        end
    end

    // Next-state, completion actions and array write strobes.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        req_n      = req;
        idx_n      = idx;
        ready_n    = ready;
        rd_data_n  = rd_data;
        rd_valid_n = 1'b0;
        addr_err_n = 1'b0;
        be_c       = '0;
        wdata_c    = (req.size == SZ_BYTE) ? {BYTE_LANES{req.wdata[7:0]}} : req.wdata;

        case (state)
            IDLE: begin
                if (ready && (mem_r_en || mem_w_en)) begin
                    req_n.is_write = mem_w_en;
                    req_n.size     = size_t'(size);
                    req_n.lane     = addr[1:0];
                    req_n.wdata    = wr_data;
                    req_n.ok       = req_ok_c;
                    idx_n          = IDX_W'((addr - DATA_W'(BASE_ADDR)) >> 2);
                    cnt_n          = CNT_W'(WAIT_CYCLES);
                    state_n        = BUSY;
                    ready_n        = 1'b0;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                    if (!req.ok) begin
                        addr_err_n = 1'b1;
                    end else if (req.is_write) begin
                        be_c = (req.size == SZ_BYTE) ? (BYTE_LANES'(1) << req.lane) : '1;
                    end else begin
                        rd_valid_n = 1'b1;
                        rd_data_n  = (req.size == SZ_BYTE)
                                     ? DATA_W'(rdata_c[{req.lane, 3'b000} +: 8])
                                     : rdata_c;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: WAIT_CYCLES=3 instance plus a WAIT_CYCLES=0 instance.
module tb_data_memory_ws;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        mem_r_en = 1'b0, mem_w_en = 1'b0, size = 1'b0;
    logic [31:0] addr = '0, wr_data = '0;
    logic        ready, rd_valid, addr_err;
    logic [31:0] rd_data;

    logic        r0 = 1'b0, w0 = 1'b0, size0 = 1'b0;
    logic [31:0] addr0 = '0, wr_data0 = '0;
    logic        ready0, rd_valid0, addr_err0;
    logic [31:0] rd_data0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_memory_ws #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .size(size),
        .addr(addr), .wr_data(wr_data), .ready(ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .addr_err(addr_err)
    );

    data_memory_ws #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_r_en(r0), .mem_w_en(w0), .size(size0),
        .addr(addr0), .wr_data(wr_data0), .ready(ready0), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .addr_err(addr_err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, then wait (bounded) for ready to return.
    task automatic access(input logic r, input logic w, input logic sz,
                          input logic [31:0] a, input logic [31:0] d,
                          output int busy, output logic [31:0] rdat,
                          output logic rv, output logic ae);
        mem_r_en = r; mem_w_en = w; size = sz; addr = a; wr_data = d;
        @(negedge clk);
        mem_r_en = 1'b0; mem_w_en = 1'b0; addr = 32'hFFFF_FFFF; wr_data = 32'h0;
        busy = 0;
        while (ready !== 1'b1 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        rdat = rd_data; rv = rd_valid; ae = addr_err;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic sz);
        int busy; logic [31:0] rdat; logic rv, ae;
        access(1'b0, 1'b1, sz, a, d, busy, rdat, rv, ae);
        check({tag, "_busy"}, 32'(busy), 32'd4);
        check({tag, "_err"}, 32'(ae), 32'd0);
        check({tag, "_rv"}, 32'(rv), 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic sz, input logic [31:0] exp);
        int busy; logic [31:0] rdat; logic rv, ae;
        access(1'b1, 1'b0, sz, a, 32'h0, busy, rdat, rv, ae);
        check({tag, "_busy"}, 32'(busy), 32'd4);
        check({tag, "_rv"}, 32'(rv), 32'd1);
        check({tag, "_err"}, 32'(ae), 32'd0);
        check({tag, "_data"}, rdat, exp);
    endtask

    task automatic err(input string tag, input logic r, input logic w, input logic sz,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] held);
        int busy; logic [31:0] rdat; logic rv, ae;
        access(r, w, sz, a, d, busy, rdat, rv, ae);
        check({tag, "_busy"}, 32'(busy), 32'd4);
        check({tag, "_err"}, 32'(ae), 32'd1);
        check({tag, "_rv"}, 32'(rv), 32'd0);
        check({tag, "_held"}, rdat, held);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rv", 32'(rd_valid), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_ready0", 32'(ready0), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Word write/read and single-cycle valid pulse
        wr("w1024", 32'd1024, 32'hDEADBEEF, 1'b0);
        rd("r1024", 32'd1024, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        check("rv_pulse", 32'(rd_valid), 32'd0);

        // Byte merge and zero-extended byte read
        wr("w1028", 32'd1028, 32'h11223344, 1'b0);
        wr("wb1029", 32'd1029, 32'hFFFFFF5A, 1'b1);
        rd("r1028", 32'd1028, 1'b0, 32'h11225A44);
        rd("rb1029", 32'd1029, 1'b1, 32'h0000005A);

        // Address errors: misaligned, below base, one past end, no aliasing on writes
        err("e1282", 1'b1, 1'b0, 1'b0, 32'd1282, 32'h0, 32'h0000005A);
        err("e1020", 1'b1, 1'b0, 1'b0, 32'd1020, 32'h0, 32'h0000005A);
        err("e1280", 1'b1, 1'b0, 1'b0, 32'd1280, 32'h0, 32'h0000005A);
        err("ew1280", 1'b0, 1'b1, 1'b0, 32'd1280, 32'h99999999, 32'h0000005A);
        err("ew1030", 1'b0, 1'b1, 1'b0, 32'd1030, 32'h77777777, 32'h0000005A);
        rd("r1024_keep", 32'd1024, 1'b0, 32'hDEADBEEF);
        rd("r1028_keep", 32'd1028, 1'b0, 32'h11225A44);

        // Last word is in range
        wr("w1276", 32'd1276, 32'h0BADCAFE, 1'b0);
        rd("r1276", 32'd1276, 1'b0, 32'h0BADCAFE);

        // Read and write together is rejected without writing
        err("e_rw", 1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 32'h0BADCAFE);
        rd("r1024_rw", 32'd1024, 1'b0, 32'hDEADBEEF);

        // Request presented while busy is ignored
        mem_r_en = 1'b1; size = 1'b0; addr = 32'd1028;
        @(negedge clk);
        check("ign_busy0", 32'(ready), 32'd0);
        mem_r_en = 1'b0; mem_w_en = 1'b1; addr = 32'd1024; wr_data = 32'h12345678;
        @(negedge clk);
        check("ign_busy1", 32'(ready), 32'd0);
        mem_w_en = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("ign_rv", 32'(rd_valid), 32'd1);
        check("ign_data", rd_data, 32'h11225A44);
        @(negedge clk);
        check("ign_no_accept", 32'(ready), 32'd1);
        check("ign_no_rv", 32'(rd_valid), 32'd0);
        check("ign_no_err", 32'(addr_err), 32'd0);
        rd("r1024_ign", 32'd1024, 1'b0, 32'hDEADBEEF);

        // Reset during a write aborts it
        wr("w1032", 32'd1032, 32'h01020304, 1'b0);
        mem_w_en = 1'b1; size = 1'b0; addr = 32'd1032; wr_data = 32'hCAFEF00D;
        @(negedge clk);
        mem_w_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_rd_data", rd_data, 32'h0);
        check("abort_rv", 32'(rd_valid), 32'd0);
        check("abort_err", 32'(addr_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rd("r1032_old", 32'd1032, 1'b0, 32'h01020304);

        // Zero wait states: one busy cycle, then back-to-back reads every 2 cycles
        w0 = 1'b1; size0 = 1'b0; addr0 = 32'd1024; wr_data0 = 32'h55AA55AA;
        @(negedge clk);
        check("z_w_busy", 32'(ready0), 32'd0);
        w0 = 1'b0;
        @(negedge clk);
        check("z_w_ready", 32'(ready0), 32'd1);
        check("z_w_err", 32'(addr_err0), 32'd0);
        r0 = 1'b1; addr0 = 32'd1024;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("z_rv%0d", i), 32'(rd_valid0), 32'(i % 2));
            check($sformatf("z_ready%0d", i), 32'(ready0), 32'(i % 2));
            if (i % 2 == 1) check($sformatf("z_data%0d", i), rd_data0, 32'h55AA55AA);
        end
        r0 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
Parametrised successor to the pipeline data-memory stage. It is a word-addressed data store with a configurable base address and depth, plus programmable wait states. It supports word and byte accesses, an address-error flag, and a ready/valid handshake that lets the MEM stage stall. The block sits between EXE/MEM and MEM/WB. It latches a request, holds ready low for the access duration, and returns read data with a one-cycle valid pulse.

Parameters:
- DATA_W, 32: data and address width; must be 32 in this core.
- DEPTH, 64: number of words in the array; power of two.
- BASE_ADDR, 1024: byte address that maps to word 0.
- WAIT_CYCLES, 3: extra busy cycles per access; 0 is legal.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- mem_r_en  in  1  read request.
- mem_w_en  in  1  write request.
- size  in  1  access size; 0 = word, 1 = byte.
- addr  in  32  byte address, taken from the ALU result.
- wr_data  in  32  store data (Val_Rm); a byte store uses wr_data[7:0].
- ready  out  1  high when idle and a request can be accepted; the upstream freeze is ~ready.
- rd_data  out  32  read result; a byte read is zero-extended.
- rd_valid  out  1  one-cycle pulse when rd_data is updated by a read.
- addr_err  out  1  one-cycle pulse when an accepted request was rejected.

Behaviour:
- Reset (rst=0 at a posedge):
  - state goes to IDLE; ready=1, rd_data=0, rd_valid=0, addr_err=0, wait counter=0.
  - Array contents are not cleared.
  - A reset during BUSY aborts the access: no write is performed and no rd_valid is issued.
- Index mapping: idx = (addr - BASE_ADDR) >> 2; byte lane = addr[1:0].
- Range check: a request is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH. Compute it with 32-bit unsigned compares; no wrap-around aliasing is allowed.
- Request validity: in range, and (size=1 or addr[1:0]=0), and not both mem_r_en and mem_w_en.
- FSM IDLE:
  - At a posedge with ready=1 and (mem_r_en | mem_w_en), the request is accepted.
  - On acceptance, latch op/size/idx/lane/wr_data and the validity result; cnt <= WAIT_CYCLES; go to BUSY; ready <= 0.
  - rd_valid and addr_err are forced to 0 on every IDLE edge that does not complete an access.
- FSM BUSY:
  - On each posedge with cnt != 0: cnt <= cnt - 1.
  - On the posedge with cnt = 0, the access completes and the FSM goes to IDLE with ready <= 1.
  - Completion, valid write: for a word access all 4 lanes are written; for a byte access only the selected lane is written and the other 3 bytes are preserved.
  - Completion, valid read: rd_data <= word, or the zero-extended selected byte; rd_valid <= 1.
  - Completion, invalid request: addr_err <= 1; no array write; rd_data is held; rd_valid stays 0.
- Latency:
  - The completion edge is WAIT_CYCLES+1 edges after the accepting edge.
  - rd_valid, addr_err and ready=1 appear together in the cycle after the completion edge.
  - ready is low for exactly WAIT_CYCLES+1 cycles.
- Inputs are ignored while ready=0; the requester does not need to hold them.
- Back-to-back requests: a new request may be accepted on the first edge at which ready=1, giving a throughput of 1 access per WAIT_CYCLES+2 cycles.
- rd_data holds its last value between reads, across writes, and across errors.

Decomposition:
- Package data_mem_pkg:
  - state enum {IDLE, BUSY}
  - size enum {SZ_WORD=0, SZ_BYTE=1}
  - BYTE_LANES=4
  - function range_ok(addr, base, depth)
- Sub-module data_mem_array: single-port DEPTH x 32 array with a 4-bit byte write-enable, synchronous write and combinational read. No reset on the array.

Test Plan:
- Reset, then word write 0xDEADBEEF to 1024 followed by a word read of 1024 → ready low 4 cycles; rd_data=0xDEADBEEF; rd_valid pulses once.
- Byte write 0x5A to 1029 over a word 0x11223344 at 1028, then word read 1028 → 0x11225A44. A byte read of 1029 → 0x0000005A.
- Word read of 1282 (misaligned), 1020 (below base), and 1280 (one past the end at DEPTH=64) → addr_err pulse each time, rd_data held, memory unchanged.
- mem_r_en=mem_w_en=1 → addr_err pulse with no write. A request driven while ready=0 is ignored: there is no extra pulse and memory is unchanged.
- Assert rst=0 two cycles into a write of 0xCAFEF00D to 1032 → outputs reset and ready=1 after that edge; a later read of 1032 returns the old value.
- WAIT_CYCLES=0 build: read → ready low 1 cycle, rd_valid in the 2nd cycle after acceptance. Back-to-back reads sustain one result every 2 cycles.
